// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM stage and its SRAM controller
// Contents: controller state type, default SRAM byte base, SRAM address/data widths,
// phase-counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SRAM_BASE_DEF = 1024;
  localparam int SRAM_AW       = 18;
  localparam int SRAM_DW       = 16;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two-phase 16-bit SRAM access controller for 32-bit words
// Purpose: splits one 32-bit access into a low and a high halfword phase, each
// SRAM_WAIT+1 cycles long, and assembles read data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_r_en/w_en   access request (write wins when both are set)
//   addr_byte       byte address of the access
//   wdata           32-bit store data
//   sram_*          registered SRAM pins (address, WE_N, data out, OE), sram_dq_in read data
//   state           current controller state
//   read_data       assembled 32-bit read word
import mem_pkg::*;

module sram_ctrl #(
  parameter int SRAM_WAIT = 1,
  parameter int SRAM_BASE = SRAM_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr_byte,
  input  logic [31:0]        wdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output state_t             state,
  output logic [31:0]        read_data
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SRAM_WAIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic               oe_q, oe_d;
  logic [SRAM_DW-1:0] dq_q, dq_d;

  logic        req;
  logic        is_write;
  logic        phase_end;
  logic [16:0] word_addr;

  assign req       = mem_r_en | mem_w_en;
  assign is_write  = mem_w_en;
  assign phase_end = (cnt_q == LAST);
  // Subtraction wraps modulo 2^32, truncation then wraps modulo 2^17 words.
  assign word_addr = 17'((addr_byte - 32'(SRAM_BASE)) >> 2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req)       state_d = S_LO;
      S_LO:    if (phase_end) state_d = S_HI;
      S_HI:    if (phase_end) state_d = S_DONE;
      default:                state_d = S_IDLE;
    endcase

    // Counter restarts on every state entry and only runs inside a phase.
    cnt_d = '0;
    if (state_d == state_q && (state_q == S_LO || state_q == S_HI))
      cnt_d = cnt_q + 1'b1;

    rdata_d = rdata_q;
    if (!is_write && phase_end) begin
      if (state_q == S_LO)      rdata_d[15:0]  = sram_dq_in;
      else if (state_q == S_HI) rdata_d[31:16] = sram_dq_in;
    end

    // Pins are registered from the next state so they line up with the state itself.
    addr_d = '0;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    dq_d   = '0;
    if (state_d == S_LO || state_d == S_HI) begin
      addr_d = {word_addr, state_d == S_HI};
      if (is_write) begin
        we_n_d = 1'b0;
        oe_d   = 1'b1;
        dq_d   = (state_d == S_HI) ? wdata[31:16] : wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
    end
  end

  assign state       = state_q;
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with SRAM access and MEM/WB register
// Purpose: runs loads/stores through sram_ctrl, stalls the pipeline while an
// access is in flight and inserts bubbles into MEM/WB during the stall.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   WB_EN_In, MEM_R_EN_In, MEM_W_EN_In    controls from EXE
//   ALU_Res, Val_Rm, Dest                 address/result, store data, destination
//   ready                                 low freezes the upstream pipeline
//   WB_EN_Out, MEM_R_EN_Out, ALU_Res_Out,
//   Mem_Data, Dest_Out                    MEM/WB register outputs
//   SRAM_ADDR, SRAM_WE_N, SRAM_DQ_Out,
//   SRAM_DQ_OE, SRAM_DQ_In                SRAM pins
import mem_pkg::*;

module mem_stage #(
  parameter int SRAM_WAIT = 1,
  parameter int SRAM_BASE = SRAM_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_EN_In,
  input  logic               MEM_R_EN_In,
  input  logic               MEM_W_EN_In,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  input  logic [3:0]         Dest,
  output logic               ready,
  output logic               WB_EN_Out,
  output logic               MEM_R_EN_Out,
  output logic [31:0]        ALU_Res_Out,
  output logic [31:0]        Mem_Data,
  output logic [3:0]         Dest_Out,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic [SRAM_DW-1:0] SRAM_DQ_Out,
  output logic               SRAM_DQ_OE,
  input  logic [SRAM_DW-1:0] SRAM_DQ_In
);

  state_t      state;
  logic [31:0] read_data;

  logic        wb_en_q, wb_en_d;
  logic        mem_r_q, mem_r_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  dest_q, dest_d;

  sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT),
    .SRAM_BASE (SRAM_BASE)
  ) u_sram_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (MEM_R_EN_In),
    .mem_w_en    (MEM_W_EN_In),
    .addr_byte   (ALU_Res),
    .wdata       (Val_Rm),
    .sram_addr   (SRAM_ADDR),
    .sram_we_n   (SRAM_WE_N),
    .sram_dq_out (SRAM_DQ_Out),
    .sram_dq_oe  (SRAM_DQ_OE),
    .sram_dq_in  (SRAM_DQ_In),
    .state       (state),
    .read_data   (read_data)
  );

  // Stall starts in the same cycle a request shows up in IDLE, so upstream freezes at once.
  assign ready = !((state == S_IDLE && (MEM_R_EN_In || MEM_W_EN_In)) ||
                   state == S_LO || state == S_HI);

  always_comb begin
    wb_en_d = 1'b0;
    mem_r_d = 1'b0;
    alu_d   = alu_q;
    data_d  = data_q;
    dest_d  = dest_q;
    if (ready) begin
      wb_en_d = WB_EN_In;
      mem_r_d = MEM_R_EN_In;
      alu_d   = ALU_Res;
      data_d  = read_data;
      dest_d  = Dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      alu_q   <= '0;
      data_q  <= '0;
      dest_q  <= '0;
    end else begin
      wb_en_q <= wb_en_d;
      mem_r_q <= mem_r_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  assign WB_EN_Out    = wb_en_q;
  assign MEM_R_EN_Out = mem_r_q;
  assign ALU_Res_Out  = alu_q;
  assign Mem_Data     = data_q;
  assign Dest_Out     = dest_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter SRAM_WAIT, default 1, is the number of extra cycles each 16-bit SRAM phase is held (phase length is SRAM_WAIT+1).
REQ-002 Parameter SRAM_BASE, default 1024, is the byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 WB_EN_In, MEM_R_EN_In, MEM_W_EN_In  input  1 each  control from the EXE stage.
REQ-006 ALU_Res  input  32  byte address for memory ops, or the result for non-memory ops.
REQ-007 Val_Rm  input  32  store data (forwarded Rm).
REQ-008 Dest  input  4  destination register.
REQ-009 ready  output  1  low means "freeze PC, IF/ID, ID/EXE and EXE/MEM this cycle".
REQ-010 WB_EN_Out, MEM_R_EN_Out  output  1 each  registered MEM/WB controls.
REQ-011 ALU_Res_Out, Mem_Data  output  32 each  registered MEM/WB data.
REQ-012 Dest_Out  output  4  registered MEM/WB destination.
REQ-013 SRAM_ADDR  output  18  halfword address.
REQ-014 SRAM_WE_N  output  1  active-low write enable.
REQ-015 SRAM_DQ_Out  output  16  write data.
REQ-016 SRAM_DQ_OE  output  1  drive enable for the data bus.
REQ-017 SRAM_DQ_In  input  16  read data.

Function
REQ-018 The controller FSM SHALL have four states: IDLE, LO, HI, DONE.
REQ-019 FSM transitions SHALL be:
- IDLE -> LO when MEM_R_EN_In or MEM_W_EN_In is high; otherwise IDLE.
- LO -> HI after SRAM_WAIT+1 cycles, counted by a phase counter cleared on each state entry.
- HI -> DONE after SRAM_WAIT+1 cycles.
- DONE -> IDLE unconditionally.
REQ-020 ready SHALL be combinational: 0 in IDLE with a request pending, 0 in LO and HI, 1 otherwise.
REQ-021 Access latency SHALL be 2*(SRAM_WAIT+1)+1 cycles with ready low, followed by one DONE cycle with ready high.
REQ-022 Address mapping SHALL be: word address w = (ALU_Res - SRAM_BASE)[18:2]; SRAM_ADDR = {w[16:0],0} in LO and {w[16:0],1} in HI; SRAM_ADDR = 0 in all other states.
REQ-023 For writes, SRAM_WE_N SHALL be 0 and SRAM_DQ_OE 1 throughout LO and HI, with SRAM_DQ_Out = Val_Rm[15:0] in LO and Val_Rm[31:16] in HI; otherwise SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_DQ_Out=0.
REQ-024 For reads, SRAM_DQ_In SHALL be captured on the final cycle of LO into read_data[15:0] and on the final cycle of HI into read_data[31:16].
REQ-025 Pipeline inputs are held stable by upstream freeze while ready=0; the block SHALL NOT latch them.
REQ-026 MEM/WB register behaviour:
- When ready=1, SHALL load WB_EN_In, MEM_R_EN_In, ALU_Res, read_data and Dest.
- When ready=0, SHALL load a bubble: WB_EN_Out=0 and MEM_R_EN_Out=0, other fields unchanged.
REQ-027 Non-memory instructions SHALL pass with zero stall: IDLE, ready=1, one-cycle register latency.
REQ-028 Back-to-back memory ops SHALL pass through DONE -> IDLE -> LO, giving exactly one ready-high cycle between accesses.
REQ-029 If MEM_R_EN_In and MEM_W_EN_In are both high, the access SHALL be performed as a write.
REQ-030 Addresses below SRAM_BASE SHALL wrap modulo 2^17 words; no error is flagged.

Reset
REQ-031 On rst high, asynchronously and regardless of clk:
- FSM to IDLE, phase counter to 0, read_data to 0.
- All MEM/WB outputs to 0.
- SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0.
REQ-032 Reset mid-access SHALL abort immediately with SRAM_WE_N forced high; a partial write is acceptable and is not completed after reset.

Structure
REQ-033 A shared package mem_pkg SHALL hold the FSM state typedef, SRAM_BASE default, SRAM address/data widths and the phase-counter width.
REQ-034 The FSM, counter, SRAM drive and read_data capture SHALL reside in sub-module sram_ctrl; mem_stage SHALL add only the MEM/WB register and the ready/bubble logic.

Verification
REQ-035 Non-memory op (WB_EN_In=1, ALU_Res=0x1234, Dest=3): after one clk, WB_EN_Out=1, ALU_Res_Out=0x1234, Dest_Out=3; ready never low.
REQ-036 Store, SRAM_WAIT=1, ALU_Res=1028, Val_Rm=0xDEADBEEF: ready low 5 cycles; SRAM_ADDR=2 with DQ=0xBEEF for 2 cycles, then SRAM_ADDR=3 with DQ=0xDEAD for 2 cycles, WE_N=0 throughout; WB_EN_Out=0 during the stall.
REQ-037 Load from ALU_Res=1028 after REQ-036: Mem_Data=0xDEADBEEF and MEM_R_EN_Out=1 on the cycle after DONE.
REQ-038 Two consecutive loads, addresses 1024 and 1032: ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
REQ-039 rst asserted in HI of a store: on the same cycle SRAM_WE_N=1 and all outputs are 0; after release the FSM is IDLE and ready=1 with no request pending.
